// File: rtl/data_sram_responder_pkg.sv
// Shared constants and helpers for the data SRAM responder.
// Config-window offsets, default decode window and byte merge.
package data_sram_responder_pkg;

  localparam logic [31:0] CONF_BASE_DEF = 32'hbfaf_0000;
  localparam logic [31:0] CONF_MASK_DEF = 32'hffff_0000;

  localparam logic [15:0] OFF_CR0       = 16'h0000;
  localparam logic [15:0] OFF_LED       = 16'hf000;
  localparam logic [15:0] OFF_SWITCH    = 16'hf020;
  localparam logic [15:0] OFF_TIMER     = 16'he000;
  localparam logic [15:0] OFF_TIMER_CMP = 16'he004;
  localparam logic [15:0] OFF_IRQ_STAT  = 16'he008;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wdata,
    input logic [3:0]  wen
  );
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (wen[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Data SRAM port between the EXE/MEM stages and the responder.
// Master drives the request, slave returns registered read data.
interface data_sram_responder_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder_sram_bank.sv
// Single-port word RAM with byte enables and a registered read port.
// No reset: contents and the read register start undefined.
module sram_bank #(
  parameter int RAM_AW = 12
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [3:0]        i_wen,
  input  logic [RAM_AW-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:2**RAM_AW-1];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (|i_wen) begin
        for (int b = 0; b < 4; b++) begin
          if (i_wen[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM target: word RAM plus a config window with scratch,
// LEDs, synchronised switches and a compare-interrupt timer.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] CONF_BASE = CONF_BASE_DEF,
  parameter logic [31:0] CONF_MASK = CONF_MASK_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  data_sram_responder_if.slave  bus,
  output logic [15:0]           led,
  input  logic [7:0]            switch,
  output logic                  timer_irq
);

  logic        w_conf_hit;
  logic        w_rd;
  logic        w_wr;
  logic        w_cwr;
  logic [15:0] w_off;
  logic [31:0] w_ram_rdata;
  logic [31:0] w_conf_rdata;

  logic        r_conf_sel;
  logic [31:0] r_conf_rdata;
  logic [31:0] r_cr0;
  logic [15:0] r_led;
  logic [7:0]  r_sw_meta;
  logic [7:0]  r_sw_sync;
  logic [31:0] r_timer;
  logic [31:0] r_cmp;
  logic        r_irq;

  assign w_conf_hit =
    (bus.data_sram_addr & CONF_MASK) == CONF_BASE;
  assign w_off = bus.data_sram_addr[15:0];
  assign w_rd  = bus.data_sram_en & ~(|bus.data_sram_wen);
  assign w_wr  = bus.data_sram_en & (|bus.data_sram_wen);
  assign w_cwr = w_wr & w_conf_hit;

  sram_bank #(.RAM_AW(RAM_AW)) u_bank (
    .clk     (clk),
    .i_en    (bus.data_sram_en & ~w_conf_hit),
    .i_wen   (bus.data_sram_wen),
    .i_addr  (bus.data_sram_addr[RAM_AW+1:2]),
    .i_wdata (bus.data_sram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_conf_rdata = 32'h0;
    case (w_off)
      OFF_CR0:       w_conf_rdata = r_cr0;
      OFF_LED:       w_conf_rdata = {16'h0, r_led};
      OFF_SWITCH:    w_conf_rdata = {24'h0, r_sw_sync};
      OFF_TIMER:     w_conf_rdata = r_timer;
      OFF_TIMER_CMP: w_conf_rdata = r_cmp;
      OFF_IRQ_STAT:  w_conf_rdata = {31'h0, r_irq};
      default:       w_conf_rdata = 32'h0;
    endcase
  end

  // Read-path select; reset points it at the zeroed config register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conf_sel   <= 1'b1;
      r_conf_rdata <= 32'h0;
    end else if (w_rd) begin
      r_conf_sel <= w_conf_hit;
      if (w_conf_hit) r_conf_rdata <= w_conf_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cr0 <= 32'h0;
      r_led <= 16'hffff;
    end else if (w_cwr) begin
      if (w_off == OFF_CR0)
        r_cr0 <= merge(r_cr0, bus.data_sram_wdata,
                       bus.data_sram_wen);
      if (w_off == OFF_LED) begin
        if (bus.data_sram_wen[0])
          r_led[7:0] <= bus.data_sram_wdata[7:0];
        if (bus.data_sram_wen[1])
          r_led[15:8] <= bus.data_sram_wdata[15:8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw_meta <= 8'h0;
      r_sw_sync <= 8'h0;
    end else begin
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
    end
  end

  // A software write to TIMER replaces that cycle's increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= 32'h0;
      r_cmp   <= 32'hffff_ffff;
      r_irq   <= 1'b0;
    end else begin
      if (w_cwr && w_off == OFF_TIMER)
        r_timer <= merge(r_timer, bus.data_sram_wdata,
                         bus.data_sram_wen);
      else
        r_timer <= r_timer + 32'd1;
      if (w_cwr && w_off == OFF_TIMER_CMP)
        r_cmp <= merge(r_cmp, bus.data_sram_wdata,
                       bus.data_sram_wen);
      if (r_timer == r_cmp)
        r_irq <= 1'b1;
      else if (w_cwr && w_off == OFF_IRQ_STAT &&
               bus.data_sram_wen[0])
        r_irq <= 1'b0;
    end
  end

  assign bus.data_sram_rdata = r_conf_sel ? r_conf_rdata
                                          : w_ram_rdata;
  assign led       = r_led;
  assign timer_irq = r_irq;

endmodule
